// File: rtl/uartx_pkg.sv
// uartx shared definitions: register map, bit positions, FSM states.
// Optional parity support is enabled by defining UARTX_PARITY_EN.
package uartx_pkg;
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd1;
    localparam logic [2:0] REG_CTRL   = 3'd2;
    localparam logic [2:0] REG_DIV    = 3'd3;
    localparam logic [2:0] REG_IE     = 3'd4;

    localparam int ST_RXAV    = 0;
    localparam int ST_TXEMPTY = 1;
    localparam int ST_TXFULL  = 2;
    localparam int ST_RXOVR   = 3;
    localparam int ST_TXOVF   = 4;
    localparam int ST_FERR    = 5;
    localparam int ST_PERR    = 6;

    localparam int CT_TXEN   = 0;
    localparam int CT_RXEN   = 1;
    localparam int CT_PAREN  = 2;
    localparam int CT_PARODD = 3;
    localparam int CT_RXTHR  = 4;

    localparam int IE_RX  = 0;
    localparam int IE_TX  = 1;
    localparam int IE_ERR = 2;

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
    } rx_state_t;
endpackage

// File: rtl/uartx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; pop on empty and push on full are ignored.
// Used for both the TX and RX character queues of uartx_apb.
module uartx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];
    assign count   = wptr - rptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/uartx_apb.sv
// APB UART with TX/RX FIFOs, 16x-oversampled baud generator and maskable interrupt.
// Define UARTX_PARITY_EN to implement PAREN/PARODD/PERR and the parity bit.
module uartx_apb
    import uartx_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_BITS  = 8,
    parameter int DIV_W      = 16
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [4:0]        PADDR,
    input  logic [XLEN-1:0]   PWDATA,
    input  logic [XLEN/8-1:0] PSTRB,
    output logic [XLEN-1:0]   PRDATA,
    output logic              PREADY,
    input  logic              SIN,
    output logic              SOUT,
    output logic              INTR
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UARTX_PARITY_EN
    localparam logic PAR_IMPL = 1'b1;
`else
    localparam logic PAR_IMPL = 1'b0;
`endif
    localparam logic [6:0] CTRL_MASK = PAR_IMPL ? 7'h7f : 7'h73;

    logic                 memwrite, memread;
    logic [2:0]           sel;
    logic [6:0]           ctrl;
    logic [2:0]           ie;
    logic [DIV_W-1:0]     div, bcnt;
    logic                 tick;
    logic                 rxovr, txovf, ferr, perr;
    logic [31:0]          w1c, rd32, thr;
    logic                 unused_ok;

    logic                 tx_push, tx_pop, tx_empty, tx_full;
    logic [DATA_BITS-1:0] tx_rdata;
    logic [AW:0]          tx_count;
    logic                 rx_push, rx_pop, rx_empty, rx_full, rx_push_req;
    logic [DATA_BITS-1:0] rx_rdata;
    logic [AW:0]          rx_count;

    tx_state_t            tx_state, tx_state_d;
    logic [3:0]           tx_tcnt, tx_tcnt_d;
    logic [2:0]           tx_bcnt, tx_bcnt_d;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_d;
    logic                 tx_par, tx_par_d;

    rx_state_t            rx_state, rx_state_d;
    logic [3:0]           rx_tcnt, rx_tcnt_d;
    logic [2:0]           rx_bcnt, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_d;
    logic                 sync1, sync2, sync3;
    logic                 ferr_set, perr_set;
    logic                 txempty;

    assign memwrite  = PSEL && PENABLE && PWRITE;
    assign memread   = PSEL && PENABLE && !PWRITE;
    assign sel       = PADDR[4:2];
    assign PREADY    = 1'b1;
    assign unused_ok = ^{PSTRB, PWDATA, PADDR[1:0], tx_count};

    assign tx_push = memwrite && sel == REG_DATA && !tx_full;
    assign rx_push = rx_push_req && !rx_full;
    assign rx_pop  = memread && sel == REG_DATA;
    assign txempty = tx_empty && tx_state == TX_IDLE;

    uartx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_txf (
        .clk(PCLK), .rst(PRESET), .push(tx_push), .pop(tx_pop),
        .wdata(PWDATA[DATA_BITS-1:0]), .rdata(tx_rdata),
        .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    uartx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_BITS)) u_rxf (
        .clk(PCLK), .rst(PRESET), .push(rx_push), .pop(rx_pop),
        .wdata(rx_sh), .rdata(rx_rdata),
        .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    // A new DIV value is only picked up when the counter reloads
    assign tick = (bcnt == '0);

    always_comb begin
        tx_state_d = tx_state;
        tx_tcnt_d  = tx_tcnt;
        tx_bcnt_d  = tx_bcnt;
        tx_sh_d    = tx_sh;
        tx_par_d   = tx_par;
        tx_pop     = 1'b0;
        if (tick) begin
            tx_tcnt_d = tx_tcnt + 4'd1;
            unique case (tx_state)
                TX_IDLE: begin
                    tx_tcnt_d = '0;
                    tx_bcnt_d = '0;
                    if (ctrl[CT_TXEN] && !tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_sh_d    = tx_rdata;
                        tx_par_d   = ^tx_rdata ^ ctrl[CT_PARODD];
                        tx_state_d = TX_START;
                    end
                end
                TX_START: if (tx_tcnt == 4'hf) tx_state_d = TX_DATA;
                TX_DATA: if (tx_tcnt == 4'hf) begin
                    tx_sh_d   = tx_sh >> 1;
                    tx_bcnt_d = tx_bcnt + 3'd1;
                    if (tx_bcnt == 3'(DATA_BITS - 1))
                        tx_state_d = ctrl[CT_PAREN] ? TX_PARITY : TX_STOP;
                end
                TX_PARITY: if (tx_tcnt == 4'hf) tx_state_d = TX_STOP;
                TX_STOP: if (tx_tcnt == 4'hf) tx_state_d = TX_IDLE;
                default: tx_state_d = TX_IDLE;
            endcase
        end
    end

    always_comb begin
        unique case (tx_state)
            TX_START:  SOUT = 1'b0;
            TX_DATA:   SOUT = tx_sh[0];
            TX_PARITY: SOUT = tx_par;
            default:   SOUT = 1'b1;
        endcase
    end

    // START is checked at mid-bit, so later 16-tick windows sample mid-bit too
    always_comb begin
        rx_state_d  = rx_state;
        rx_tcnt_d   = rx_tcnt;
        rx_bcnt_d   = rx_bcnt;
        rx_sh_d     = rx_sh;
        rx_push_req = 1'b0;
        ferr_set    = 1'b0;
        perr_set    = 1'b0;
        if (rx_state == RX_IDLE) begin
            rx_tcnt_d = '0;
            rx_bcnt_d = '0;
            if (ctrl[CT_RXEN] && sync3 && !sync2) rx_state_d = RX_START;
        end else if (tick) begin
            rx_tcnt_d = rx_tcnt + 4'd1;
            unique case (rx_state)
                RX_START: if (rx_tcnt == 4'd7) begin
                    rx_tcnt_d  = '0;
                    rx_state_d = sync2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: if (rx_tcnt == 4'hf) begin
                    rx_sh_d   = {sync2, rx_sh[DATA_BITS-1:1]};
                    rx_bcnt_d = rx_bcnt + 3'd1;
                    if (rx_bcnt == 3'(DATA_BITS - 1))
                        rx_state_d = ctrl[CT_PAREN] ? RX_PARITY : RX_STOP;
                end
                RX_PARITY: if (rx_tcnt == 4'hf) begin
                    perr_set   = PAR_IMPL && (sync2 != (^rx_sh ^ ctrl[CT_PARODD]));
                    rx_state_d = RX_STOP;
                end
                RX_STOP: if (rx_tcnt == 4'hf) begin
                    rx_push_req = 1'b1;
                    ferr_set    = !sync2;
                    rx_state_d  = RX_IDLE;
                end
                default: rx_state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            bcnt     <= '0;
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_sh    <= '0;
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            sync3    <= 1'b1;
        end else begin
            bcnt     <= tick ? div : bcnt - 1'b1;
            tx_state <= tx_state_d;
            tx_tcnt  <= tx_tcnt_d;
            tx_bcnt  <= tx_bcnt_d;
            tx_sh    <= tx_sh_d;
            tx_par   <= tx_par_d;
            rx_state <= rx_state_d;
            rx_tcnt  <= rx_tcnt_d;
            rx_bcnt  <= rx_bcnt_d;
            rx_sh    <= rx_sh_d;
            sync1    <= SIN;
            sync2    <= sync1;
            sync3    <= sync2;
        end
    end

    assign w1c = (memwrite && sel == REG_STATUS) ? PWDATA[31:0] : '0;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            ctrl  <= '0;
            ie    <= '0;
            div   <= DIV_W'(1);
            rxovr <= 1'b0;
            txovf <= 1'b0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
        end else begin
            if (memwrite && sel == REG_CTRL) ctrl <= PWDATA[6:0] & CTRL_MASK;
            if (memwrite && sel == REG_DIV)  div  <= PWDATA[DIV_W-1:0];
            if (memwrite && sel == REG_IE)   ie   <= PWDATA[2:0];
            rxovr <= (rxovr & ~w1c[ST_RXOVR]) | (rx_push_req && rx_full);
            txovf <= (txovf & ~w1c[ST_TXOVF]) | (memwrite && sel == REG_DATA && tx_full);
            ferr  <= (ferr & ~w1c[ST_FERR]) | ferr_set;
            perr  <= (perr & ~w1c[ST_PERR]) | perr_set;
        end
    end

    always_comb begin
        rd32 = '0;
        unique case (sel)
            REG_DATA:   rd32 = rx_empty ? '0 : 32'(rx_rdata);
            REG_STATUS: rd32 = 32'({perr, ferr, txovf, rxovr, tx_full, txempty, !rx_empty});
            REG_CTRL:   rd32 = 32'(ctrl);
            REG_DIV:    rd32 = 32'(div);
            REG_IE:     rd32 = 32'(ie);
            default:    rd32 = '0;
        endcase
    end

    assign PRDATA = memread ? {(XLEN/32){rd32}} : '0;

    assign thr = (32'(ctrl[CT_RXTHR +: 3]) + 32'd1 > 32'(FIFO_DEPTH))
               ? 32'(FIFO_DEPTH) : 32'(ctrl[CT_RXTHR +: 3]) + 32'd1;

    assign INTR = (ie[IE_RX] && 32'(rx_count) >= thr)
               || (ie[IE_TX] && txempty)
               || (ie[IE_ERR] && (rxovr || txovf || ferr || perr));
endmodule
